// File: rtl/qspline_sdiv_30s_16s_16_seq.sv
// Radix-2 restoring signed divider (30s / 16s -> saturated 16s quotient), fixed latency.
// Optional remainder output enabled by defining QSPLINE_SDIV_REM_EN; otherwise rem is tied to 0.
module qspline_sdiv_30s_16s_16_seq #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 16,
    parameter int QUOT_W     = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     dout,
    output logic [QUOT_W-1:0]     rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam int PAD_W = DIVIDEND_W - QUOT_W + 2;
    localparam logic signed [DIVIDEND_W:0] QMAX = {{PAD_W{1'b0}}, {(QUOT_W-1){1'b1}}};
    localparam logic signed [DIVIDEND_W:0] QMIN = {{PAD_W{1'b1}}, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sgn_n_q, sgn_n_d;
    logic                    sgn_d_q, sgn_d_d;
    logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]    pr_q, pr_d;
    logic [DIVIDEND_W-1:0]   quo_q, quo_d;
    logic [QUOT_W-1:0]       dout_q, dout_d;
    logic                    ovf_q, ovf_d;
    logic                    dz_q, dz_d;

    logic [DIVISOR_W:0]        shifted;
    logic [DIVISOR_W+1:0]      diff;
    logic                      qbit;
    logic signed [DIVIDEND_W:0] qs;

    assign shifted = {pr_q, dvd_q[DIVIDEND_W-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign qbit    = ~diff[DIVISOR_W+1];
    assign qs      = (sgn_n_q ^ sgn_d_q) ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});

`ifdef QSPLINE_SDIV_REM_EN
    logic [QUOT_W-1:0] rem_q, rem_d;
    logic [QUOT_W-1:0] rem_fix;
    logic [QUOT_W-1:0] dvd_low;

    assign rem_fix = sgn_n_q ? QUOT_W'(-pr_q) : QUOT_W'(pr_q);
    // dvd_q has rotated back to |din0| by FIX, so this recovers din0's low bits
    assign dvd_low = sgn_n_q ? QUOT_W'(-dvd_q) : QUOT_W'(dvd_q);

    always_comb begin
        rem_d = rem_q;
        if (state_q == StFix) begin
            rem_d = (dvs_q == '0) ? dvd_low : rem_fix;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rem_q <= '0;
        end else if (ce) begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;
`else
    assign rem = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_n_d = sgn_n_q;
        sgn_d_d = sgn_d_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sgn_n_d = din0[DIVIDEND_W-1];
                    sgn_d_d = din1[DIVISOR_W-1];
                    dvd_d   = din0[DIVIDEND_W-1] ? -din0 : din0;
                    dvs_d   = din1[DIVISOR_W-1] ? -din1 : din1;
                    pr_d    = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // Rotate rather than shift so the dividend magnitude survives to FIX
                dvd_d = {dvd_q[DIVIDEND_W-2:0], dvd_q[DIVIDEND_W-1]};
                pr_d  = qbit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
                quo_d = {quo_q[DIVIDEND_W-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dvs_q == '0) begin
                    dz_d   = 1'b1;
                    ovf_d  = 1'b1;
                    dout_d = {sgn_n_q, {(QUOT_W-1){~sgn_n_q}}};
                end else if (qs > QMAX) begin
                    dz_d   = 1'b0;
                    ovf_d  = 1'b1;
                    dout_d = {1'b0, {(QUOT_W-1){1'b1}}};
                end else if (qs < QMIN) begin
                    dz_d   = 1'b0;
                    ovf_d  = 1'b1;
                    dout_d = {1'b1, {(QUOT_W-1){1'b0}}};
                end else begin
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    dout_d = qs[QUOT_W-1:0];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sgn_n_q <= 1'b0;
            sgn_d_q <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_n_q <= sgn_n_d;
            sgn_d_q <= sgn_d_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign dout = dout_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_qspline_sdiv_30s_16s_16_seq.sv
// Self-checking bench for qspline_sdiv_30s_16s_16_seq: vector table, random model, corner sequences.
module tb_qspline_sdiv_30s_16s_16_seq;

    typedef struct {
        logic signed [29:0] a;
        logic signed [15:0] b;
        logic [15:0]        q;
        logic [15:0]        r;
        logic               ovf;
        logic               dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start;
    logic [29:0] din0;
    logic [15:0] din1;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dz;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    qspline_sdiv_30s_16s_16_seq dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .ce     (ce),
        .start  (start),
        .din0   (din0),
        .din1   (din1),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .rem    (rem),
        .ovf    (ovf),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] rem_mask(input logic [15:0] r);
`ifdef QSPLINE_SDIV_REM_EN
        return r;
`else
        return 16'h0000 & r;
`endif
    endfunction

    function automatic exp_t model(input logic signed [29:0] a, input logic signed [15:0] b);
        exp_t   e;
        longint la = a;
        longint lb = b;
        longint q;
        longint r;
        e.a = a;
        e.b = b;
        if (lb == 0) begin
            e.dz  = 1'b1;
            e.ovf = 1'b1;
            e.q   = (la < 0) ? 16'h8000 : 16'h7FFF;
            r     = la;
        end else begin
            q    = la / lb;
            r    = la % lb;
            e.dz = 1'b0;
            if (q > 32767) begin
                e.q = 16'h7FFF; e.ovf = 1'b1;
            end else if (q < -32768) begin
                e.q = 16'h8000; e.ovf = 1'b1;
            end else begin
                e.q = q[15:0]; e.ovf = 1'b0;
            end
        end
        e.r = rem_mask(r[15:0]);
        return e;
    endfunction

    // Drives one division; stall>0 drops ce at that many random edges, pulse fires a stray start.
    task automatic run_op(input exp_t e, input int stall, input bit pulse);
        int   edges;
        int   p0, p1, p2;
        exp_t got;
        p0 = $urandom_range(3, 10);
        p1 = p0 + $urandom_range(1, 5);
        p2 = p1 + $urandom_range(1, 5);
        exp_q.push_back(e);
        din0  = e.a;
        din1  = e.b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        chk("busy_after_capture", 32'(busy), 32'd1);
        while (!done && edges < 100) begin
            ce = !(stall > 0 && (edges == p0 || (stall > 1 && edges == p1) ||
                                 (stall > 2 && edges == p2)));
            if (pulse && edges == 5) begin
                start = 1'b1; din0 = 30'd123; din1 = 16'd3;
            end else begin
                start = 1'b0; din0 = e.a; din1 = e.b;
            end
            @(posedge clk); #1;
            edges++;
        end
        ce    = 1'b1;
        start = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done after %0d edges, expected within 100", edges);
            void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: done with empty queue, expected one entry");
            return;
        end
        got = exp_q.pop_front();
        chk("latency", 32'(edges), 32'(32 + stall));
        chk("dout", 32'(dout), 32'(got.q));
        chk("rem", 32'(rem), 32'(got.r));
        chk("ovf", 32'(ovf), 32'(got.ovf));
        chk("dz", 32'(dz), 32'(got.dz));
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
        chk("dout_hold", 32'(dout), 32'(got.q));
    endtask

    exp_t tbl[8];
    logic signed [29:0] ra;
    logic signed [15:0] rb;
    bit saw_done;

    initial begin
        tbl[0] = '{a: 30'sd1000,       b: 16'sd7,  q: 16'd142,    r: 16'd6,    ovf: 0, dz: 0};
        tbl[1] = '{a: -30'sd1000,      b: 16'sd7,  q: 16'hFF72,   r: 16'hFFFA, ovf: 0, dz: 0};
        tbl[2] = '{a: 30'sd1000,       b: -16'sd7, q: 16'hFF72,   r: 16'd6,    ovf: 0, dz: 0};
        tbl[3] = '{a: 30'sd536870911,  b: 16'sd1,  q: 16'h7FFF,   r: 16'd0,    ovf: 1, dz: 0};
        tbl[4] = '{a: -30'sd536870912, b: -16'sd1, q: 16'h7FFF,   r: 16'd0,    ovf: 1, dz: 0};
        tbl[5] = '{a: -30'sd32768,     b: 16'sd1,  q: 16'h8000,   r: 16'd0,    ovf: 0, dz: 0};
        tbl[6] = '{a: 30'sd5,          b: 16'sd0,  q: 16'h7FFF,   r: 16'd5,    ovf: 1, dz: 1};
        tbl[7] = '{a: -30'sd5,         b: 16'sd0,  q: 16'h8000,   r: 16'hFFFB, ovf: 1, dz: 1};

        rst = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            tbl[i].r = rem_mask(tbl[i].r);
            run_op(tbl[i], 0, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            if (i[0]) begin
                ra = 30'($urandom);
                rb = 16'($urandom);
            end else begin
                ra = 30'($urandom_range(0, 2000000)) - 30'sd1000000;
                rb = 16'($urandom_range(1, 300));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            run_op(model(ra, rb), 0, 1'b0);
        end

        run_op(model(30'sd1000, 16'sd7), 3, 1'b0);
        run_op(model(30'sd1000, 16'sd7), 0, 1'b1);

        // Abort mid-CALC: outputs clear at once and no done follows
        din0 = 30'sd99999; din1 = 16'sd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_rem", 32'(rem), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        run_op(model(-30'sd123456, 16'sd321), 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
